// File: rtl/memref_rd_streamer.sv
// ---------------------------------------------------------------------------
// memref_rd_streamer
//    Read initiator for a memref memory port. A tstart pulse samples
//    base_addr/count/stride; the block then reads count words at addresses
//    (base_addr + k*stride) mod SIZE and returns them on a valid/ready
//    stream, flagging the final word with out_last. A small return FIFO plus
//    credit-based issue means a stalled consumer never loses a word.
//
// Ports
//    clk, rst_n     clock, asynchronous active-low reset
//    tstart         start pulse (ignored while busy)
//    base_addr      first read address
//    count          number of words, 0..SIZE
//    stride         address increment per word, modulo SIZE
//    mem_addr       memory read address (holds when mem_rd_en=0)
//    mem_rd_en      memory read enable
//    mem_rd_data    memory read data, valid the cycle after mem_rd_en
//    out_valid/out_ready/out_data/out_last   result stream
//    busy           transfer in progress
//    done           one-cycle pulse after the final word is accepted
//    stall_cnt      (MEMREF_RD_STREAMER_PERF_EN only) cycles with
//                   out_valid & !out_ready & busy, saturating
//
// Configuration macro: MEMREF_RD_STREAMER_PERF_EN
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module memref_rd_streamer #(
   parameter int WIDTH      = 32,
   parameter int SIZE       = 64,
   parameter int ADDR_W     = $clog2(SIZE),
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tstart,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic [ADDR_W-1:0] stride,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [WIDTH-1:0]  mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
`ifdef MEMREF_RD_STREAMER_PERF_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_W:0] ONE_WORD = 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, stride_reg, addr_step;
   logic [ADDR_W:0]     addr_sum;
   logic [ADDR_W:0]     issue_left_reg, pop_left_reg;
   logic                in_flight_reg;
   logic                done_reg;
   logic [WIDTH-1:0]    fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [OCC_W-1:0]    occ_reg;
   logic [OCC_W:0]      credit_used;
   logic                accept, start_run, push, pop, final_pop, room;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign accept    = tstart && (state_reg == IDLE);
   assign start_run = accept && (count != '0);
   assign push      = in_flight_reg;   // data returns one cycle after each read
   assign pop       = out_valid && out_ready;
   assign final_pop = pop && (pop_left_reg == ONE_WORD);

   // Words already owed to the FIFO (stored + in flight) minus the one leaving
   // this cycle; a new read is only issued if it is guaranteed a slot.
   assign credit_used = {1'b0, occ_reg} + (OCC_W+1)'(in_flight_reg) - (OCC_W+1)'(pop);
   assign room        = credit_used < (OCC_W+1)'(FIFO_DEPTH);

   // Next address, wrapping modulo SIZE (works for non-power-of-two SIZE).
   assign addr_sum  = {1'b0, addr_reg} + {1'b0, stride_reg};
   assign addr_step = (addr_sum >= (ADDR_W+1)'(SIZE)) ?
                      ADDR_W'(addr_sum - (ADDR_W+1)'(SIZE)) : addr_sum[ADDR_W-1:0];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_run) state_next = ISSUE;
         ISSUE:   if (mem_rd_en && (issue_left_reg == ONE_WORD)) state_next = DRAIN;
         DRAIN:   if (final_pop) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      mem_rd_en = 1'b0;
      busy      = 1'b0;
      if (state_reg == ISSUE) mem_rd_en = room;
      if (state_reg != IDLE)  busy = 1'b1;
   end

   // ---------------- Datapath and FIFO control ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg       <= '0;
         stride_reg     <= '0;
         issue_left_reg <= '0;
         pop_left_reg   <= '0;
         in_flight_reg  <= 1'b0;
         done_reg       <= 1'b0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         occ_reg        <= '0;
      end else begin
         in_flight_reg <= mem_rd_en;
         done_reg      <= final_pop || (accept && (count == '0));

         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (push && !pop)      occ_reg <= occ_reg + 1'b1;
         else if (!push && pop) occ_reg <= occ_reg - 1'b1;

         if (start_run) begin
            addr_reg       <= base_addr;
            stride_reg     <= stride;
            issue_left_reg <= count;
            pop_left_reg   <= count;
         end else begin
            if (mem_rd_en) begin
               issue_left_reg <= issue_left_reg - ONE_WORD;
               // Do not step past the final read so mem_addr holds it.
               if (issue_left_reg != ONE_WORD) addr_reg <= addr_step;
            end
            if (pop) pop_left_reg <= pop_left_reg - ONE_WORD;
         end
      end
   end

   // FIFO storage: plain array, no reset needed (reads are gated by out_valid).
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= mem_rd_data;
   end

   assign mem_addr  = addr_reg;
   assign out_valid = (occ_reg != '0);
   assign out_data  = out_valid ? fifo_mem[rd_ptr_reg] : '0;
   assign out_last  = out_valid && (pop_left_reg == ONE_WORD);
   assign done      = done_reg;

`ifdef MEMREF_RD_STREAMER_PERF_EN
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else if (accept) begin
         stall_cnt_reg <= '0;
      end else if (out_valid && !out_ready && busy && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_memref_rd_streamer.sv
`timescale 1ns/1ps

module tb_memref_rd_streamer;

   localparam int WIDTH      = 32;
   localparam int SIZE       = 64;
   localparam int ADDR_W     = 6;
   localparam int FIFO_DEPTH = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              tstart;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W-1:0] stride;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [WIDTH-1:0]  mem_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic              out_last;
   logic              busy;
   logic              done;
`ifdef MEMREF_RD_STREAMER_PERF_EN
   logic [31:0]       stall_cnt;
`endif

   memref_rd_streamer #(
      .WIDTH(WIDTH), .SIZE(SIZE), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tstart(tstart),
      .base_addr(base_addr), .count(count), .stride(stride),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
`ifdef MEMREF_RD_STREAMER_PERF_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: registered read, mem[i] = i+1.
   logic [WIDTH-1:0] mem [SIZE];
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard
   logic [WIDTH:0]    exp_data_q[$];
   logic [ADDR_W-1:0] exp_addr_q[$];
   int start_cyc, first_rden, first_valid, done_rel, done_count;
   int outstanding, max_outst;
   bit prev_stall;
   logic [WIDTH-1:0] prev_data;

   // Monitor: samples on the falling edge, pops expectations as the DUT acts.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (first_valid < 0) first_valid = cyc - start_cyc;
            if (prev_stall) check("head_stable", out_data, prev_data);
            if (out_ready) begin
               if (exp_data_q.size() == 0) begin
                  check("unexpected_word", 1, 0);
               end else begin
                  logic [WIDTH:0] e;
                  e = exp_data_q.pop_front();
                  check("out_data", out_data, e[WIDTH-1:0]);
                  check("out_last", out_last, e[WIDTH]);
                  $display("word %0d last=%0d cycle=%0d", out_data, out_last, cyc - start_cyc);
               end
               outstanding--;
            end
            prev_stall = !out_ready;
            prev_data  = out_data;
         end else begin
            if (prev_stall) check("valid_dropped_in_stall", 0, 1);
            prev_stall = 0;
         end
         if (mem_rd_en) begin
            if (first_rden < 0) first_rden = cyc - start_cyc;
            if (exp_addr_q.size() == 0) begin
               check("unexpected_rd_en", 1, 0);
            end else begin
               logic [ADDR_W-1:0] a;
               a = exp_addr_q.pop_front();
               check("mem_addr", mem_addr, a);
            end
            outstanding++;
         end
         if (outstanding > max_outst) max_outst = outstanding;
         if (done) begin
            done_count++;
            done_rel = cyc - start_cyc;
            check("busy_at_done", busy, 0);
         end
      end
   end

   task automatic start_xfer(input int b, input int c, input int s);
      start_cyc = cyc; first_rden = -1; first_valid = -1; done_rel = -1;
      done_count = 0; max_outst = 0; outstanding = 0;
      for (int k = 0; k < c; k++) begin
         int a;
         a = (b + k * s) % SIZE;
         exp_addr_q.push_back(ADDR_W'(a));
         exp_data_q.push_back({(k == c - 1), mem[a]});
      end
      tstart = 1'b1; base_addr = ADDR_W'(b); count = (ADDR_W+1)'(c); stride = ADDR_W'(s);
      @(posedge clk); #1;
      tstart = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (done_count == 0 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      if (done_count == 0) check("done_timeout", 0, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_rd_en"}, mem_rd_en, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_out_last"}, out_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < SIZE; i++) mem[i] = WIDTH'(i + 1);
      rst_n = 1'b1; tstart = 1'b0; base_addr = '0; count = '0; stride = '0;
      out_ready = 1'b1; mem_rd_data = '0;
      start_cyc = 0; first_rden = -1; first_valid = -1; done_rel = -1;
      done_count = 0; outstanding = 0; max_outst = 0; prev_stall = 0; prev_data = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
`ifdef MEMREF_RD_STREAMER_PERF_EN
      check("reset_stall_cnt", stall_cnt, 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: base 0, count 4, stride 1
      start_xfer(0, 4, 1);
      wait_done(30);
      repeat (2) @(posedge clk); #1;
      check("t1_first_rd_en_cycle", first_rden, 1);
      check("t1_first_valid_cycle", first_valid, 3);
      check("t1_done_cycle", done_rel, 7);
      check("t1_done_count", done_count, 1);
      check("t1_words_left", exp_data_q.size(), 0);
      $display("test1 done at cycle %0d", done_rel);

      // 2: address wrap 62,63,0,1
      start_xfer(62, 4, 1);
      wait_done(30);
      check("t2_done_cycle", done_rel, 7);
      check("t2_words_left", exp_data_q.size(), 0);
      check("t2_addrs_left", exp_addr_q.size(), 0);
      $display("test2 done at cycle %0d", done_rel);

      // 3: consumer stalls cycles 0..8
      out_ready = 1'b0;
      start_xfer(0, 4, 1);
      repeat (8) @(posedge clk);
      #1 out_ready = 1'b1;
      wait_done(30);
      check("t3_max_outstanding", max_outst, FIFO_DEPTH);
      check("t3_done_cycle", done_rel, 13);
      check("t3_words_left", exp_data_q.size(), 0);
`ifdef MEMREF_RD_STREAMER_PERF_EN
      check("t3_stall_cnt", stall_cnt, 6);
`endif
      $display("test3 done at cycle %0d max outstanding %0d", done_rel, max_outst);

      // 4: count 0
      start_xfer(5, 0, 1);
      wait_done(10);
      repeat (2) @(posedge clk); #1;
      check("t4_done_cycle", done_rel, 1);
      check("t4_no_rd_en", first_rden, -1);
      check("t4_no_valid", first_valid, -1);
      $display("test4 done at cycle %0d", done_rel);

      // 5: second tstart while busy is ignored
      start_xfer(0, 8, 1);
      @(posedge clk); #1;
      tstart = 1'b1; base_addr = 20; count = 3; stride = 5;
      @(posedge clk); #1;
      tstart = 1'b0;
      wait_done(40);
      repeat (5) @(posedge clk); #1;
      check("t5_done_count", done_count, 1);
      check("t5_done_cycle", done_rel, 11);
      check("t5_words_left", exp_data_q.size(), 0);
      $display("test5 done at cycle %0d", done_rel);

      // 6: reset mid-transfer, then a fresh transfer
      start_xfer(8, 8, 8);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      exp_data_q.delete(); exp_addr_q.delete();
      outstanding = 0; prev_stall = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      check("t6_no_done_after_reset", done_count, 0);
      start_xfer(8, 8, 8);
      wait_done(40);
      check("t6_done_cycle", done_rel, 11);
      check("t6_words_left", exp_data_q.size(), 0);
      check("t6_addrs_left", exp_addr_q.size(), 0);
      $display("test6 done at cycle %0d", done_rel);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
